mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one single-outstanding memory bus port between instruction fetch (IF) and load/store (LS, MEM stage).
//  Sequences each transfer with a 3-state FSM: arbitrate, address handshake, response wait.
//  Routes responses back to the transfer's owner.
//  Discards IF responses killed by a pipeline jump flush.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width
//  STARVE_MAX  4   consecutive LS grants tolerated while if_req pending (ARB_STARVE_GUARD_EN only)
// PORTS
//  clk        in   1     single clock, all logic posedge
//  rst        in   1     synchronous, active-high reset
//  if_req     in   1     IF request; holds if_addr stable until if_gnt
//  if_addr    in   AW    fetch address
//  if_flush   in   1     jump taken; kill the IF transfer in flight
//  if_gnt     out  1     1-cycle pulse: IF request accepted by bus
//  if_rvalid  out  1     IF read data valid
//  if_rdata   out  DW    IF read data
//  ls_req     in   1     LS request; holds payload stable until ls_gnt
//  ls_we      in   1     1 = store
//  ls_addr    in   AW    LS address
//  ls_wdata   in   DW    store data
//  ls_wstrb   in   DW/8  byte strobes
//  ls_gnt     out  1     1-cycle pulse: LS request accepted
//  ls_rvalid  out  1     load data / store ack valid
//  ls_rdata   out  DW    load data
//  m_req      out  1     bus request, registered
//  m_we/m_addr/m_wdata/m_wstrb  out  1/AW/DW/DW/8  registered bus payload
//  m_gnt      in   1     bus accepts when m_req && m_gnt
//  m_rvalid   in   1     exactly one response per accepted transfer, reads and writes
//  m_rdata    in   DW    response data
// BEHAVIOUR
//  Reset: state=IDLE, owner=IF, m_req=0, m_* payload=0, drop=0, starve_cnt=0.
//   All *_gnt and *_rvalid outputs are 0.
//  IDLE: if ls_req or if_req, pick a winner (LS > IF), latch its payload into the m_* registers, set owner, go ADDR.
//   m_req rises 1 cycle after the request is seen.
//  ADDR: m_req=1 and payload held stable.
//   On m_gnt: pulse owner's *_gnt in this same cycle, drop m_req next cycle, go RESP.
//  RESP: on m_rvalid:
//   - owner's *_rvalid = 1 combinationally; *_rdata = m_rdata.
//   - Same cycle: if any req pending, arbitrate and go ADDR (zero-bubble back-to-back). Otherwise go IDLE.
//  if_gnt/if_rvalid never coincide with ls_gnt/ls_rvalid.
//  Flush:
//   - if_flush in ADDR or RESP with owner=IF: set drop. Transfer still completes on the bus (no retraction).
//   - While drop=1, or if_flush in the same cycle, if_gnt and if_rvalid are suppressed.
//   - drop clears when the response arrives.
//   - if_flush with owner=LS or in IDLE: no effect.
//  m_rvalid outside RESP (e.g. after reset mid-transfer): ignored, no *_rvalid.
//  Requester dropping req before gnt is a protocol violation (assert in sim).
//  rdata outputs = m_rdata unconditionally; qualified only by *_rvalid.
// CONFIGURATION
//  `ARB_STARVE_GUARD_EN defined:
//   - starve_cnt increments on each LS win while if_req=1; clears on any IF win or when if_req=0.
//   - At starve_cnt==STARVE_MAX, the next arbitration goes to IF even if ls_req=1; the counter then clears.
//  Undefined: strict LS priority; starve_cnt and STARVE_MAX are absent.
// STRUCTURE
//  defines.v: `ARB_IDLE/`ARB_ADDR/`ARB_RESP state codes (2 bits), `OWN_IF/`OWN_LS codes.
//  Sub-module arb_starve_cnt (counter + force_if output), instantiated only under ARB_STARVE_GUARD_EN.
//  FSM, payload registers and response routing stay in the top module.
// TESTING
//  1 IF-only: if_req, addr 0x100; m_gnt at 1st ADDR cycle; m_rvalid 2 cycles later with 0x00000013
//    -> m_req high 1 cycle after req; if_gnt 1 pulse; if_rvalid with rdata 0x00000013.
//  2 Contention: if_req and ls_req (load 0x2000) in the same IDLE cycle -> LS served first.
//    IF issued in the RESP cycle that returns LS data; no idle bubble.
//  3 Flush: IF transfer in RESP, if_flush=1 one cycle before m_rvalid -> no if_rvalid.
//    A following IF req to 0x200 completes normally.
//  4 Store: ls_we=1, addr 0x3000, wdata 0xDEADBEEF, wstrb 4'b0011 -> m_* match exactly.
//    ls_rvalid on ack.
//  5 Starvation (`ARB_STARVE_GUARD_EN, STARVE_MAX=4): ls_req and if_req held high -> IF wins the 5th arbitration.
//    Without the macro, IF never wins.
//  6 Reset asserted in RESP, then stray m_rvalid -> state IDLE, no *_rvalid, m_req=0.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the IF/LS memory bus arbiter.
// Holds the FSM state codes and the transfer-owner codes.
// The top module and the starvation counter both import this package.
package mem_bus_arbiter_pkg;

  // Transfer sequencing: arbitrate, address handshake, response wait.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  // Requester that owns the transfer currently on the bus.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Purpose: counts consecutive LS wins while IF waits; forces an IF win at STARVE_MAX.
// Latency: force_if is a registered compare, valid for the arbitration that follows.
// Backpressure: none; it only observes arbitration events.
// Ports: clk, rst (sync, active high), arb_fire (arbitration this cycle),
//        ls_win (LS won it), if_req (IF pending), force_if (next win must go to IF).
// Present only when ARB_STARVE_GUARD_EN is defined; the default build leaves this file empty.
`ifdef ARB_STARVE_GUARD_EN
module arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_fire,
  input  logic ls_win,
  input  logic if_req,
  output logic force_if
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!if_req) begin
      // Nobody is starving, so the run of LS wins no longer matters.
      cnt <= '0;
    end else if (arb_fire) begin
      // An IF win (forced or natural) restarts the run.
      cnt <= ls_win ? cnt + 1'b1 : '0;
    end
  end

  assign force_if = (cnt == CW'(STARVE_MAX));

endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one single-outstanding memory bus between IF fetch and LS (MEM stage).
// Latency: m_req rises 1 cycle after a request in IDLE; back-to-back re-issue in the response cycle.
// Backpressure: requesters hold req until their gnt pulse; the bus stalls us through m_gnt/m_rvalid.
// Ports: clk, rst (sync, active high);
//        IF side  if_req/if_addr/if_flush -> if_gnt/if_rvalid/if_rdata;
//        LS side  ls_req/ls_we/ls_addr/ls_wdata/ls_wstrb -> ls_gnt/ls_rvalid/ls_rdata;
//        bus side m_req/m_we/m_addr/m_wdata/m_wstrb (registered) <- m_gnt/m_rvalid/m_rdata.
// Optional: ARB_STARVE_GUARD_EN adds the STARVE_MAX parameter and the IF anti-starvation counter.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_MAX = 4
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_flush,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_wstrb,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wstrb,
  input  logic            m_gnt,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata
);

  arb_state_e state, state_nxt;
  owner_e     owner;
  logic       drop;
  logic       arb_fire;
  logic       pick_ls;
  logic       force_if;
  logic       addr_fire;
  logic       resp_fire;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .arb_fire (arb_fire),
    .ls_win   (arb_fire && pick_ls),
    .if_req   (if_req),
    .force_if (force_if)
  );
`else
  assign force_if = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    arb_fire  = 1'b0;
    addr_fire = 1'b0;
    resp_fire = 1'b0;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    // LS has priority unless the starvation guard says IF has waited long enough.
    pick_ls   = ls_req && !(if_req && force_if);

    case (state)
      ARB_IDLE: begin
        if (ls_req || if_req) begin
          arb_fire  = 1'b1;
          state_nxt = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        if (m_gnt) begin
          addr_fire = 1'b1;
          state_nxt = ARB_RESP;
          // A flushed fetch still completes on the bus, but the fetch unit must not see it.
          if_gnt    = (owner == OWN_IF) && !drop && !if_flush;
          ls_gnt    = (owner == OWN_LS);
        end
      end
      ARB_RESP: begin
        if (m_rvalid) begin
          resp_fire = 1'b1;
          if_rvalid = (owner == OWN_IF) && !drop && !if_flush;
          ls_rvalid = (owner == OWN_LS);
          // Re-arbitrate in the response cycle so back-to-back transfers have no bubble.
          if (ls_req || if_req) begin
            arb_fire  = 1'b1;
            state_nxt = ARB_ADDR;
          end else begin
            state_nxt = ARB_IDLE;
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Payload registers; the winner's request is frozen here for the whole handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner   <= OWN_IF;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
      drop    <= 1'b0;
    end else begin
      if (arb_fire) begin
        m_req <= 1'b1;
        if (pick_ls) begin
          owner   <= OWN_LS;
          m_we    <= ls_we;
          m_addr  <= ls_addr;
          m_wdata <= ls_wdata;
          m_wstrb <= ls_wstrb;
        end else begin
          owner   <= OWN_IF;
          m_we    <= 1'b0;
          m_addr  <= if_addr;
          m_wdata <= '0;
          m_wstrb <= '0;
        end
      end else if (addr_fire) begin
        m_req <= 1'b0;
      end

      // The response retires the killed fetch; a new transfer starts clean.
      if (resp_fire) begin
        drop <= 1'b0;
      end else if (if_flush && (owner == OWN_IF) &&
                   ((state == ARB_ADDR) || (state == ARB_RESP))) begin
        drop <= 1'b1;
      end
    end
  end

  // Data is a straight wire; the rvalid strobes say who it belongs to.
  assign if_rdata = m_rdata;
  assign ls_rdata = m_rdata;

`ifndef SYNTHESIS
  // Requesters must hold their request until granted; a flush lets IF abandon its fetch.
  a_ls_hold: assert property (@(posedge clk) disable iff (rst)
    (ls_req && !ls_gnt) |=> ls_req);
  a_if_hold: assert property (@(posedge clk) disable iff (rst)
    (if_req && !if_gnt && !if_flush && !drop) |=> (if_req || if_flush));
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose: self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized
//          run checked against a transaction-level model of requesters and bus.
// Ports: none (top-level bench).
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] RD_KEY = 32'h5A5A_0F0F;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_flush;
  logic            if_gnt;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;
  logic            ls_req;
  logic            ls_we;
  logic [AW-1:0]   ls_addr;
  logic [DW-1:0]   ls_wdata;
  logic [DW/8-1:0] ls_wstrb;
  logic            ls_gnt;
  logic            ls_rvalid;
  logic [DW-1:0]   ls_rdata;
  logic            m_req;
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic            m_gnt;
  logic            m_rvalid;
  logic [DW-1:0]   m_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  // Drive just after the rising edge, sample a little later in the same cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
    m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
    repeat (3) tick();
    settle();
    total++;
    if ({m_req, m_we, m_addr, m_wdata, m_wstrb} !== '0) begin
      bad++;
      $display("FAIL reset_bus got req=%0b we=%0b addr=%h wdata=%h wstrb=%h want all 0",
               m_req, m_we, m_addr, m_wdata, m_wstrb);
    end
    total++;
    if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid} !== 4'b0) begin
      bad++;
      $display("FAIL reset_strobes got %b want 0000", {if_gnt, ls_gnt, if_rvalid, ls_rvalid});
    end
    tick();
    rst = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
    settle();
    total++;
    if (m_req !== 1'b0) begin
      bad++; $display("FAIL reset_idle_req got %0b want 0", m_req);
    end
  endtask

  task automatic test_if_only();
    tick(); if_req = 1'b1; if_addr = 32'h100; settle();
    total++;
    if (m_req !== 1'b0) begin
      bad++; $display("FAIL if_only_req_lag got %0b want 0", m_req);
    end
    tick(); m_gnt = 1'b1; settle();
    total++;
    if (m_req !== 1'b1 || m_addr !== 32'h100 || m_we !== 1'b0) begin
      bad++; $display("FAIL if_only_payload got req=%0b addr=%h we=%0b want 1/100/0", m_req, m_addr, m_we);
    end
    total++;
    if (if_gnt !== 1'b1 || ls_gnt !== 1'b0) begin
      bad++; $display("FAIL if_only_gnt got if=%0b ls=%0b want 1/0", if_gnt, ls_gnt);
    end
    tick(); if_req = 1'b0; m_gnt = 1'b0; settle();
    total++;
    if (m_req !== 1'b0 || if_gnt !== 1'b0) begin
      bad++; $display("FAIL if_only_pulse got req=%0b gnt=%0b want 0/0", m_req, if_gnt);
    end
    tick(); m_rvalid = 1'b1; m_rdata = 32'h0000_0013; settle();
    total++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h13 || ls_rvalid !== 1'b0) begin
      bad++; $display("FAIL if_only_resp got v=%0b d=%h lsv=%0b want 1/00000013/0", if_rvalid, if_rdata, ls_rvalid);
    end
    tick(); m_rvalid = 1'b0; settle();
    total++;
    if (if_rvalid !== 1'b0 || m_req !== 1'b0) begin
      bad++; $display("FAIL if_only_idle got v=%0b req=%0b want 0/0", if_rvalid, m_req);
    end
  endtask

  task automatic test_contention();
    tick(); if_req = 1'b1; if_addr = 32'h400;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h2000; settle();
    tick(); m_gnt = 1'b1; settle();
    total++;
    if (m_addr !== 32'h2000 || ls_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      bad++; $display("FAIL contend_ls_first got addr=%h ls=%0b if=%0b want 2000/1/0", m_addr, ls_gnt, if_gnt);
    end
    tick(); ls_req = 1'b0; m_gnt = 1'b0; settle();
    tick(); m_rvalid = 1'b1; m_rdata = 32'hCAFE_0001; settle();
    total++;
    if (ls_rvalid !== 1'b1 || ls_rdata !== 32'hCAFE_0001 || if_rvalid !== 1'b0) begin
      bad++; $display("FAIL contend_ls_resp got v=%0b d=%h ifv=%0b want 1/cafe0001/0", ls_rvalid, ls_rdata, if_rvalid);
    end
    tick(); m_rvalid = 1'b0; m_gnt = 1'b1; settle();
    total++;
    if (m_req !== 1'b1 || m_addr !== 32'h400 || if_gnt !== 1'b1) begin
      bad++; $display("FAIL contend_no_bubble got req=%0b addr=%h gnt=%0b want 1/400/1", m_req, m_addr, if_gnt);
    end
    tick(); if_req = 1'b0; m_gnt = 1'b0; settle();
    tick(); m_rvalid = 1'b1; m_rdata = 32'h0BAD_F00D; settle();
    total++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL contend_if_resp got v=%0b d=%h want 1/0badf00d", if_rvalid, if_rdata);
    end
    tick(); m_rvalid = 1'b0; settle();
  endtask

  task automatic test_flush();
    // Flush during RESP, one cycle ahead of the response.
    tick(); if_req = 1'b1; if_addr = 32'h180; settle();
    tick(); m_gnt = 1'b1; settle();
    tick(); if_req = 1'b0; m_gnt = 1'b0; if_flush = 1'b1; settle();
    tick(); if_flush = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h77;
    if_req = 1'b1; if_addr = 32'h200; settle();
    total++;
    if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0) begin
      bad++; $display("FAIL flush_resp_kill got if=%0b ls=%0b want 0/0", if_rvalid, ls_rvalid);
    end
    tick(); m_rvalid = 1'b0; m_gnt = 1'b1; settle();
    total++;
    if (m_req !== 1'b1 || m_addr !== 32'h200 || if_gnt !== 1'b1) begin
      bad++; $display("FAIL flush_next_gnt got req=%0b addr=%h gnt=%0b want 1/200/1", m_req, m_addr, if_gnt);
    end
    tick(); if_req = 1'b0; m_gnt = 1'b0; settle();
    tick(); m_rvalid = 1'b1; m_rdata = 32'h99; settle();
    total++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h99) begin
      bad++; $display("FAIL flush_next_resp got v=%0b d=%h want 1/00000099", if_rvalid, if_rdata);
    end
    // Flush during ADDR: the later bus grant must stay hidden from IF.
    tick(); m_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h240; settle();
    tick(); if_req = 1'b0; if_flush = 1'b1; settle();
    tick(); if_flush = 1'b0; m_gnt = 1'b1; settle();
    total++;
    if (m_req !== 1'b1 || if_gnt !== 1'b0) begin
      bad++; $display("FAIL flush_addr_gnt got req=%0b gnt=%0b want 1/0", m_req, if_gnt);
    end
    tick(); m_gnt = 1'b0; m_rvalid = 1'b1; settle();
    total++;
    if (if_rvalid !== 1'b0) begin
      bad++; $display("FAIL flush_addr_resp got %0b want 0", if_rvalid);
    end
    tick(); m_rvalid = 1'b0; settle();
  endtask

  task automatic test_store();
    tick(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h3000;
    ls_wdata = 32'hDEAD_BEEF; ls_wstrb = 4'b0011; settle();
    tick(); settle();
    total++;
    if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h3000 ||
        m_wdata !== 32'hDEAD_BEEF || m_wstrb !== 4'b0011 || ls_gnt !== 1'b0) begin
      bad++; $display("FAIL store_payload got req=%0b we=%0b addr=%h wd=%h ws=%b gnt=%0b want 1/1/3000/deadbeef/0011/0",
                      m_req, m_we, m_addr, m_wdata, m_wstrb, ls_gnt);
    end
    tick(); m_gnt = 1'b1; settle();
    total++;
    if (m_addr !== 32'h3000 || m_wdata !== 32'hDEAD_BEEF || ls_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      bad++; $display("FAIL store_gnt got addr=%h wd=%h ls=%0b if=%0b want 3000/deadbeef/1/0",
                      m_addr, m_wdata, ls_gnt, if_gnt);
    end
    tick(); ls_req = 1'b0; ls_we = 1'b0; m_gnt = 1'b0; settle();
    // A flush while LS owns the bus must not touch the LS ack.
    tick(); m_rvalid = 1'b1; if_flush = 1'b1; m_rdata = '0; settle();
    total++;
    if (ls_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin
      bad++; $display("FAIL store_ack got ls=%0b if=%0b want 1/0", ls_rvalid, if_rvalid);
    end
    tick(); m_rvalid = 1'b0; if_flush = 1'b0; settle();
  endtask

  task automatic test_starve();
    int n = 0;
    int first_if = 0;
    int want_if;
    bit ls_on = 1'b1;
    bit if_on = 1'b1;
    bit acc_prev = 1'b0;
    bit fin = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    want_if = 4 + 1;
`else
    want_if = 9;    // only once LS stops asking after its 8th grant
`endif
    for (int c = 0; c < 80 && !fin; c++) begin
      tick();
      m_gnt = 1'b1; m_rvalid = acc_prev; m_rdata = 32'(c);
      ls_req = ls_on; ls_we = 1'b0; ls_addr = 32'h5000; if_req = if_on; if_addr = 32'h600;
      settle();
      if (!ls_on && !if_on && !acc_prev) fin = 1'b1;
      acc_prev = m_req && m_gnt;
      if (acc_prev) begin
        n++;
        if (if_gnt && first_if == 0) first_if = n;
        if (ls_gnt && n >= 8) ls_on = 1'b0;
        if (if_gnt && n >= 8) if_on = 1'b0;
      end
    end
    m_gnt = 1'b0; m_rvalid = 1'b0; ls_req = 1'b0; if_req = 1'b0;
    total++;
    if (!fin) begin
      bad++; $display("FAIL starve_timeout got grants=%0d want drained", n);
    end
    total++;
    if (first_if != want_if) begin
      bad++; $display("FAIL starve_first_if got %0d want %0d", first_if, want_if);
    end
  endtask

  task automatic test_reset_mid();
    tick(); if_req = 1'b1; if_addr = 32'h500; settle();
    tick(); m_gnt = 1'b1; settle();
    tick(); if_req = 1'b0; m_gnt = 1'b0; settle();
    tick(); rst = 1'b1; settle();
    tick(); rst = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hFFFF_0000; settle();
    total++;
    if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0 || m_req !== 1'b0) begin
      bad++; $display("FAIL rst_mid_stray got ifv=%0b lsv=%0b req=%0b want 0/0/0", if_rvalid, ls_rvalid, m_req);
    end
    tick(); m_rvalid = 1'b0; settle();
    total++;
    if (m_req !== 1'b0) begin
      bad++; $display("FAIL rst_mid_idle got %0b want 0", m_req);
    end
  endtask

  task automatic test_random();
    bit          if_pend = 1'b0, ls_pend = 1'b0, out_vld = 1'b0, out_we = 1'b0;
    bit          out_own = 1'b0, ls_w = 1'b0, idle = 1'b0;
    logic [31:0] if_a = '0, ls_a = '0, ls_d = '0, out_addr = '0, exp_d;
    logic [3:0]  ls_s = '0;
    int          out_lat = 0, issued = 0, retired = 0;
    for (int c = 0; c < 3600 && !idle; c++) begin
      if (c >= 3000 && !if_pend && !ls_pend && !out_vld) begin
        idle = 1'b1;
      end else begin
        tick();
        m_gnt = ($urandom_range(0, 2) != 0);
        if (out_vld && out_lat == 0) begin
          m_rvalid = 1'b1;
          m_rdata  = out_we ? $urandom : (out_addr ^ RD_KEY);
        end else begin
          m_rvalid = 1'b0;
          m_rdata  = $urandom;
          if (out_vld) out_lat--;
        end
        if (!if_pend && c < 3000 && $urandom_range(0, 3) == 0) begin
          if_pend = 1'b1; if_a = $urandom & 32'hFFFF_FFFC; issued++;
        end
        if (!ls_pend && c < 3000 && $urandom_range(0, 3) == 0) begin
          ls_pend = 1'b1; ls_a = $urandom; ls_w = $urandom_range(0, 1) == 1;
          ls_d = $urandom; ls_s = 4'($urandom); issued++;
        end
        if_req = if_pend; if_addr = if_a;
        ls_req = ls_pend; ls_addr = ls_a; ls_we = ls_w; ls_wdata = ls_d; ls_wstrb = ls_s;
        settle();

        total++;
        if ((if_gnt && ls_gnt) || (if_rvalid && ls_rvalid)) begin
          bad++; $display("FAIL rnd_exclusive cyc=%0d gnt=%b rv=%b want not both", c, {if_gnt, ls_gnt}, {if_rvalid, ls_rvalid});
        end
        total++;
        if (if_rdata !== m_rdata || ls_rdata !== m_rdata) begin
          bad++; $display("FAIL rnd_rdata_wire cyc=%0d if=%h ls=%h want %h", c, if_rdata, ls_rdata, m_rdata);
        end
        if (out_vld) begin
          total++;
          if (m_req !== 1'b0) begin
            bad++; $display("FAIL rnd_single_out cyc=%0d m_req=%0b want 0", c, m_req);
          end
        end
        if (m_rvalid) begin
          exp_d = out_addr ^ RD_KEY;
          total++;
          if (if_rvalid !== !out_own || ls_rvalid !== out_own) begin
            bad++; $display("FAIL rnd_route cyc=%0d ifv=%0b lsv=%0b want owner=%0d", c, if_rvalid, ls_rvalid, out_own);
          end else if (!out_we) begin
            total++;
            if ((out_own ? ls_rdata : if_rdata) !== exp_d) begin
              bad++; $display("FAIL rnd_rdata cyc=%0d got %h want %h", c, out_own ? ls_rdata : if_rdata, exp_d);
            end
          end
          out_vld = 1'b0; retired++;
        end else begin
          total++;
          if (if_rvalid || ls_rvalid) begin
            bad++; $display("FAIL rnd_spurious_rv cyc=%0d ifv=%0b lsv=%0b want 0/0", c, if_rvalid, ls_rvalid);
          end
        end
        if (m_req && m_gnt) begin
          total++;
          if (if_gnt == ls_gnt) begin
            bad++; $display("FAIL rnd_accept_gnt cyc=%0d if=%0b ls=%0b want exactly one", c, if_gnt, ls_gnt);
          end
          out_vld = 1'b1; out_lat = $urandom_range(0, 3);
          if (if_gnt) begin
            total++;
            if (m_addr !== if_a || m_we !== 1'b0) begin
              bad++; $display("FAIL rnd_if_payload cyc=%0d addr=%h we=%0b want %h/0", c, m_addr, m_we, if_a);
            end
            out_own = 1'b0; out_addr = if_a; out_we = 1'b0; if_pend = 1'b0;
          end else begin
            total++;
            if (m_addr !== ls_a || m_we !== ls_w || m_wdata !== ls_d || m_wstrb !== ls_s) begin
              bad++; $display("FAIL rnd_ls_payload cyc=%0d got %h/%0b/%h/%b want %h/%0b/%h/%b",
                              c, m_addr, m_we, m_wdata, m_wstrb, ls_a, ls_w, ls_d, ls_s);
            end
            out_own = 1'b1; out_addr = ls_a; out_we = ls_w; ls_pend = 1'b0;
          end
        end else begin
          total++;
          if (if_gnt || ls_gnt) begin
            bad++; $display("FAIL rnd_gnt_no_accept cyc=%0d if=%0b ls=%0b want 0/0", c, if_gnt, ls_gnt);
          end
        end
      end
    end
    if_req = 1'b0; ls_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
    total++;
    if (!idle) begin
      bad++; $display("FAIL rnd_drain_timeout if=%0b ls=%0b out=%0b want all 0", if_pend, ls_pend, out_vld);
    end
    total++;
    if (issued != retired) begin
      bad++; $display("FAIL rnd_count got retired=%0d want issued=%0d", retired, issued);
    end
  endtask

  initial begin
    test_reset();
    test_if_only();
    test_contention();
    test_flush();
    test_store();
    test_starve();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
